cmd_stream_bridge: RTL

Parametrised byte-to-command bridge between a byte source (UART receiver) and a graphite-style AXI-stream command port, all in the `clk_pix` domain. It assembles `WORD_BYTES` consecutive bytes into one command word in configurable byte order. Completed words are buffered in a `FIFO_DEPTH`-entry first-word-fall-through FIFO, with backpressure on both sides. It adds an inter-byte timeout that discards stale partial words, a flush input, and status counters; the open-coded 4-byte/no-buffer assembler it replaces had none of these.

---
 rtl/cmd_stream_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cmd_stream_bridge.sv
// Byte-to-command bridge: packs WORD_BYTES bytes into a word and queues
// words in a first-word-fall-through FIFO toward an AXI-stream sink.
module cmd_stream_bridge #(
  parameter int WORD_BYTES     = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                        clk_pix,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic                        byte_valid_i,
  output logic                        byte_ready_o,
  input  logic [7:0]                  byte_data_i,
  output logic                        cmd_axis_tvalid_o,
  input  logic                        cmd_axis_tready_i,
  output logic [8*WORD_BYTES-1:0]     cmd_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        err_timeout_o,
  output logic [7:0]                  drop_count_o
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_e;

  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic          err_q, err_d;
  logic [7:0]    drop_q, drop_d;

  logic          last;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fire;
  logic [CW-1:0] lane;
  state_e        state;

  assign state  = (byte_cnt_q == '0) ? S_IDLE : S_COLLECT;
  assign last   = (byte_cnt_q == LAST_IDX);
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Only the final byte needs FIFO room; full ignores a same-cycle pop.
  assign byte_ready_o = !(last && full);
  assign accept       = byte_valid_i && byte_ready_o;
  assign push         = accept && last;
  assign pop          = !empty && cmd_axis_tready_i;
  assign lane = BIG_ENDIAN ? (LAST_IDX - byte_cnt_q) : byte_cnt_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    sr_d       = sr_q;
    fire       = 1'b0;
    if (accept) begin
      sr_d[{lane, 3'b000} +: 8] = byte_data_i;
      byte_cnt_d = last ? '0 : byte_cnt_q + CW'(1);
      idle_d     = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          idle_d = '0;
        end
        S_COLLECT: begin
          if (!TO_EN) begin
            idle_d = '0;
          end else if (idle_q == TO_LAST) begin
            fire       = 1'b1;
            byte_cnt_d = '0;
            idle_d     = '0;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
        default: begin
          idle_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    err_d  = fire;
    drop_d = drop_q;
    if (fire && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset || flush_i) begin
      byte_cnt_q <= '0;
      idle_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Drop count survives a flush; only reset clears it.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      drop_q <= '0;
    end else if (!flush_i) begin
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (accept) begin
      sr_q <= sr_d;
    end
    if (push && !flush_i && !reset) begin
      mem_q[wr_q[AW-1:0]] <= sr_d;
    end
  end

  assign cmd_axis_tvalid_o = !empty;
  assign cmd_axis_tdata_o  = mem_q[rd_q[AW-1:0]];
  assign level_o           = wr_q - rd_q;
  assign err_timeout_o     = err_q;
  assign drop_count_o      = drop_q;

endmodule
